// File: rtl/pcileech_vfifo_pkg.sv
// Shared widths and word types for the vFIFO <-> FT601 width converters.
// The word-select helper defines the output order, with word 0 = bits [31:0].
package pcileech_vfifo_pkg;

  localparam int VFIFO_WIDTH     = 256;
  localparam int FT601_WIDTH     = 32;
  localparam int WORDS_PER_VFIFO = VFIFO_WIDTH / FT601_WIDTH;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_VFIFO);

  typedef logic [VFIFO_WIDTH-1:0] vfifo_word_t;
  typedef logic [FT601_WIDTH-1:0] ft601_word_t;
  typedef logic [WORD_IDX_W-1:0]  word_idx_t;

  function automatic ft601_word_t vfifo_word_select(input vfifo_word_t w, input word_idx_t idx);
    return w[idx*FT601_WIDTH +: FT601_WIDTH];
  endfunction

endpackage

// File: rtl/pcileech_vfifo_unpack_entry.sv
// One 256-bit ping-pong storage entry with its full flag.
// Load and release never coincide because load is only issued to an empty entry.
module pcileech_vfifo_unpack_entry
  import pcileech_vfifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  vfifo_word_t data_i,
  input  logic        release_i,
  output vfifo_word_t data_o,
  output logic        full_o
);

  vfifo_word_t data_q;
  logic        full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (release_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/pcileech_vfifo_unpack.sv
// Unpacks 256-bit vFIFO words into eight 32-bit FT601 words through a two-entry
// ping-pong store, served on a 1-cycle-latency req/valid/empty pull interface.
module pcileech_vfifo_unpack
  import pcileech_vfifo_pkg::*;
#(
  parameter int PARAM_IN_WIDTH  = 256,
  parameter int PARAM_OUT_WIDTH = 32,
  parameter int PARAM_WORDS     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PARAM_IN_WIDTH-1:0]  vfifo_out_data,
  input  logic                       vfifo_out_valid,
  output logic                       vfifo_out_ready,
  input  logic                       ft601_tx_rden,
  output logic [PARAM_OUT_WIDTH-1:0] ft601_tx_dout,
  output logic                       ft601_tx_valid,
  output logic                       ft601_tx_empty,
  output logic [31:0]                ft601_tx_words
);

  localparam word_idx_t LAST_IDX = word_idx_t'(PARAM_WORDS - 1);

  logic        wrSel_q, wrSel_d;
  logic        rdSel_q, rdSel_d;
  word_idx_t   idx_q, idx_d;
  logic [31:0] txWords_q, txWords_d;
  logic        txValid_q, txValid_d;
  ft601_word_t txDout_q, txDout_d;

  logic [1:0]  entryFull;
  logic [1:0]  entryLoad;
  logic [1:0]  entryRelease;
  vfifo_word_t entryData [2];

  logic        inAccept;
  logic        rdAccept;
  logic        lastWord;
  vfifo_word_t rdWord;

  for (genvar e = 0; e < 2; e++) begin : g_entry
    pcileech_vfifo_unpack_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .load_i    (entryLoad[e]),
      .data_i    (vfifo_out_data),
      .release_i (entryRelease[e]),
      .data_o    (entryData[e]),
      .full_o    (entryFull[e])
    );
  end

  // Ready looks only at the write entry's flag before any release this cycle,
  // so a freed entry is offered again one cycle after its last read.
  assign vfifo_out_ready = ~rst & ~entryFull[wrSel_q];
  assign ft601_tx_empty  = rst | ~entryFull[rdSel_q];

  assign inAccept = vfifo_out_valid & vfifo_out_ready;
  assign rdAccept = ft601_tx_rden & ~ft601_tx_empty;
  assign lastWord = (idx_q == LAST_IDX);
  assign rdWord   = entryData[rdSel_q];

  always_comb begin
    entryLoad    = '0;
    entryRelease = '0;
    if (inAccept) begin
      entryLoad[wrSel_q] = 1'b1;
    end
    if (rdAccept && lastWord) begin
      entryRelease[rdSel_q] = 1'b1;
    end
  end

  always_comb begin
    wrSel_d   = wrSel_q;
    rdSel_d   = rdSel_q;
    idx_d     = idx_q;
    txWords_d = txWords_q;
    txValid_d = 1'b0;
    txDout_d  = txDout_q;
    if (inAccept) begin
      wrSel_d = ~wrSel_q;
    end
    if (rdAccept) begin
      txValid_d = 1'b1;
      txDout_d  = vfifo_word_select(rdWord, idx_q);
      txWords_d = txWords_q + 32'd1;
      if (lastWord) begin
        idx_d   = '0;
        rdSel_d = ~rdSel_q;
      end else begin
        idx_d = idx_q + word_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrSel_q   <= 1'b0;
      rdSel_q   <= 1'b0;
      idx_q     <= '0;
      txWords_q <= '0;
      txValid_q <= 1'b0;
      txDout_q  <= '0;
    end else begin
      wrSel_q   <= wrSel_d;
      rdSel_q   <= rdSel_d;
      idx_q     <= idx_d;
      txWords_q <= txWords_d;
      txValid_q <= txValid_d;
      txDout_q  <= txDout_d;
    end
  end

  assign ft601_tx_dout  = txDout_q;
  assign ft601_tx_valid = txValid_q;
  assign ft601_tx_words = txWords_q;

endmodule

// File: tb/tb_pcileech_vfifo_unpack.sv
// Scoreboard bench for pcileech_vfifo_unpack: accepted input words push their
// eight slices into a queue that a negedge monitor pops on every valid output.
module tb_pcileech_vfifo_unpack;
  import pcileech_vfifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  vfifo_word_t vfifoOutData;
  logic        vfifoOutValid;
  logic        vfifoOutReady;
  logic        txRden;
  ft601_word_t txDout;
  logic        txValid;
  logic        txEmpty;
  logic [31:0] txWords;

  int          checks = 0;
  int          errors = 0;
  ft601_word_t expQ[$];

  pcileech_vfifo_unpack dut (
    .clk             (clk),
    .rst             (rst),
    .vfifo_out_data  (vfifoOutData),
    .vfifo_out_valid (vfifoOutValid),
    .vfifo_out_ready (vfifoOutReady),
    .ft601_tx_rden   (txRden),
    .ft601_tx_dout   (txDout),
    .ft601_tx_valid  (txValid),
    .ft601_tx_empty  (txEmpty),
    .ft601_tx_words  (txWords)
  );

  always #5 clk = ~clk;

  function automatic vfifo_word_t makeWord(input logic [15:0] tag);
    vfifo_word_t w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = {tag, 16'(i)};
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input vfifo_word_t w);
    for (int i = 0; i < 8; i++) expQ.push_back(w[i*32 +: 32]);
  endtask

  // Called at a negedge; inputs are seen by the next posedge and the task
  // returns on the following negedge, where that edge's results are visible.
  task automatic applyStimulus(input logic inValid, input vfifo_word_t inData, input logic rden,
                               output logic accepted);
    vfifoOutValid = inValid;
    vfifoOutData  = inData;
    txRden        = rden;
    #1;
    accepted = inValid && (vfifoOutReady === 1'b1);
    if (accepted) pushWord(inData);
    @(negedge clk);
  endtask

  task automatic resetDut();
    #1;
    checkOutput("sbDrained", expQ.size(), 0);
    expQ.delete();
    rst           = 1'b1;
    vfifoOutValid = 1'b0;
    txRden        = 1'b0;
    @(negedge clk);
    checkOutput("readyInReset", vfifoOutReady, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (txValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sbUnderflow: actual=%0h required=no output", txDout);
      end else begin
        checkOutput("sbDout", txDout, expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    int          sent, stalls, validCount, gaps, accCount;
    logic        started;
    vfifo_word_t streamWords [4];

    rst           = 1'b1;
    vfifoOutValid = 1'b0;
    vfifoOutData  = '0;
    txRden        = 1'b0;

    $display("[TB] reset and idle");
    resetDut();
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("idleReady", vfifoOutReady, 1);
    checkOutput("idleEmpty", txEmpty, 1);
    checkOutput("idleValid", txValid, 0);
    checkOutput("idleWords", txWords, 0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("idleRdenValid", txValid, 0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("idleRdenValid2", txValid, 0);
    checkOutput("idleRdenWords", txWords, 0);

    $display("[TB] single word");
    resetDut();
    applyStimulus(1'b1, makeWord(16'h0000), 1'b0, acc);
    checkOutput("singleAccept", acc, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1, acc);
      checkOutput("singleValid", txValid, 1);
    end
    checkOutput("singleEmpty", txEmpty, 1);
    checkOutput("singleWords", txWords, 8);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("singleValidDrop", txValid, 0);

    $display("[TB] streaming");
    resetDut();
    for (int i = 0; i < 4; i++) streamWords[i] = makeWord(16'h1100 + 16'(i));
    sent = 0; stalls = 0; validCount = 0; gaps = 0; started = 1'b0;
    for (int cyc = 0; cyc < 100 && validCount < 32; cyc++) begin
      applyStimulus(sent < 4, streamWords[sent % 4], 1'b1, acc);
      if (acc) sent++;
      else if (sent < 4) stalls++;
      if (txValid === 1'b1) begin
        validCount++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
    end
    checkOutput("streamValidCount", validCount, 32);
    checkOutput("streamGaps", gaps, 0);
    checkOutput("streamSent", sent, 4);
    checkOutput("streamStalls", stalls, 14);
    checkOutput("streamWords", txWords, 32);
    checkOutput("streamEmpty", txEmpty, 1);

    $display("[TB] backpressure");
    resetDut();
    applyStimulus(1'b1, makeWord(16'h2206), 1'b0, acc);
    checkOutput("bpAccept0", acc, 1);
    applyStimulus(1'b1, makeWord(16'h2207), 1'b0, acc);
    checkOutput("bpAccept1", acc, 1);
    accCount = 0; validCount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, makeWord(16'h2208), 1'b0, acc);
      if (acc) accCount++;
      if (txValid === 1'b1) validCount++;
    end
    checkOutput("bpHeldAccepts", accCount, 0);
    checkOutput("bpHeldValids", validCount, 0);
    checkOutput("bpHeldReady", vfifoOutReady, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, makeWord(16'h2208), 1'b1, acc);
      if (acc) accCount++;
      if (i < 7) checkOutput("bpReadyDuringDrain", vfifoOutReady, 0);
    end
    checkOutput("bpDrainAccepts", accCount, 0);
    checkOutput("bpReadyAfterRelease", vfifoOutReady, 1);
    applyStimulus(1'b1, makeWord(16'h2208), 1'b1, acc);
    checkOutput("bpThirdAccept", acc, 1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("bpWords", txWords, 24);
    checkOutput("bpEmpty", txEmpty, 1);

    $display("[TB] gapped reads");
    resetDut();
    applyStimulus(1'b1, makeWord(16'h3309), 1'b0, acc);
    checkOutput("gapAccept", acc, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, '0, (i % 2) == 0, acc);
      checkOutput("gapValid", txValid, (i % 2) == 0);
    end
    checkOutput("gapWords", txWords, 8);
    checkOutput("gapEmpty", txEmpty, 1);

    $display("[TB] reset mid-drain");
    resetDut();
    applyStimulus(1'b1, makeWord(16'h440A), 1'b0, acc);
    checkOutput("midAccept0", acc, 1);
    applyStimulus(1'b1, makeWord(16'h440B), 1'b0, acc);
    checkOutput("midAccept1", acc, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("midWordsBefore", txWords, 3);
    #1;
    expQ.delete();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("midResetReady", vfifoOutReady, 0);
    checkOutput("midResetValid", txValid, 0);
    checkOutput("midResetEmpty", txEmpty, 1);
    checkOutput("midResetWords", txWords, 0);
    rst = 1'b0;
    applyStimulus(1'b1, makeWord(16'h550C), 1'b0, acc);
    checkOutput("midReloadAccept", acc, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("midReloadWords", txWords, 8);
    checkOutput("midReloadEmpty", txEmpty, 1);

    #1;
    checkOutput("sbFinal", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcileech_vfifo_unpack.md
Name: pcileech_vfifo_unpack

Overview:
- Read-side width converter between the 256-bit vFIFO output and the 32-bit FT601 transmit port of pcileech_ft601.
- Accepts 256-bit words on a valid/ready handshake and buffers them in a two-entry ping-pong store.
- Serves them as eight 32-bit words through the FT601 controller's req/valid/empty pull interface.
- Mirror of the packing performed on the vFIFO input side.

Parameters:
PARAM_IN_WIDTH, 256, input word width; fixed at 256, other values unsupported.
PARAM_OUT_WIDTH, 32, output word width; fixed at 32.
PARAM_WORDS, 8, output words per input word (PARAM_IN_WIDTH / PARAM_OUT_WIDTH).

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  synchronous active-high reset.
vfifo_out_data  in  256  256-bit word from vFIFO.
vfifo_out_valid  in  1  vfifo_out_data valid.
vfifo_out_ready  out  1  unpacker can accept a 256-bit word this cycle.
ft601_tx_rden  in  1  FT601 controller requests one 32-bit word (din_req_data).
ft601_tx_dout  out  32  output word (din).
ft601_tx_valid  out  1  ft601_tx_dout valid this cycle (din_wr_en).
ft601_tx_empty  out  1  no 32-bit word available (din_empty).
ft601_tx_words  out  32  count of 32-bit words delivered since reset, wraps at 2^32.

Behaviour:
- Storage
  - Two 256-bit entries buf[0], buf[1], each with a full flag.
  - wr_sel: entry the next input word is written to.
  - rd_sel: entry currently being drained.
  - idx[2:0]: next output word within buf[rd_sel].
- Reset (sync, rst=1 at a clk edge) clears all state:
  - full flags=0, wr_sel=0, rd_sel=0, idx=0, ft601_tx_words=0.
  - Outputs: vfifo_out_ready=0 during the reset cycle; ft601_tx_valid=0, ft601_tx_empty=1, ft601_tx_dout=0.
  - Reset mid-operation discards all buffered data; partially drained words are lost.
- Input handshake
  - vfifo_out_ready = ~rst & ~full[wr_sel], registered-state derived, no combinational path from vfifo_out_valid.
  - On valid&ready: buf[wr_sel] <= data, full[wr_sel] <= 1, wr_sel toggles.
  - Back-to-back valid cycles are permitted and are accepted while ready=1.
- Output handshake
  - ft601_tx_empty = ~full[rd_sel] (combinational from registers).
  - On ft601_tx_rden & ~ft601_tx_empty at edge N, at edge N+1:
    - ft601_tx_valid=1.
    - ft601_tx_dout = buf[rd_sel][32*idx +: 32].
    - idx increments; ft601_tx_words increments.
  - Latency is 1 cycle, matching a standard-FIFO read.
  - ft601_tx_rden while empty is ignored: valid=0 next cycle, no state change.
  - ft601_tx_valid is 0 in any cycle not following an accepted read; dout holds its last value.
- Word order: word 0 = bits [31:0] is sent first; word 7 = bits [255:224] is sent last.
- Entry release
  - On the accepted read with idx=7: full[rd_sel] <= 0, rd_sel toggles, idx <= 0.
  - The other entry, if full, is readable in the very next cycle, giving sustained 1 word/clk with no bubble.
- Simultaneous load and release of the same entry in one cycle:
  - Cannot occur: ready uses full[wr_sel] before release.
  - The freed entry is reported ready on the following cycle (1-cycle turnaround).
- Both entries full: ready=0 until entry release.
- Both entries empty: empty=1; ready=1.
- No ordering violation: wr_sel and rd_sel each toggle strictly alternately.
- FSM, per entry: EMPTY -> FULL on accept; FULL -> DRAINING on first read; DRAINING -> EMPTY on eighth read. The state is encoded by full flag plus (rd_sel, idx).

Decomposition:
- Shared package pcileech_vfifo_pkg:
  - VFIFO_WIDTH=256, FT601_WIDTH=32, WORDS_PER_VFIFO=8.
  - Typedef vfifo_word_t [255:0].
  - Typedef ft601_word_t [31:0].
- One natural sub-module: pcileech_vfifo_unpack_entry. It holds a 256-bit register, its full flag, and load/release controls, and is instantiated twice.
- The mux and idx logic stay in the top module.

Test Plan:
- Reset then idle: rst 2 cycles, then deassert.
  - Response: ready=1, empty=1, valid=0, words=0.
  - rden pulses produce no valid.
- Single word: load 256'h...0000_0007_..._0000_0001_0000_0000 (word i = i), then rden held 8 cycles.
  - Response: valid 8 consecutive cycles, dout 0,1,...,7 in order.
  - Empty=1 after the 8th read; words=8.
- Streaming: 4 input words presented back-to-back (valid held high) with rden always 1.
  - Response: 32 consecutive valid cycles with no gap after the first word loads.
  - Input words 3 and 4 stall (ready=0) until entries free; words=32.
- Backpressure: load two words, rden=0 for 20 cycles.
  - Response: ready=0 after the second accept, the third valid held.
  - Then rden 1 cycle: dout = word0 of entry 0; ready stays 0 until 8 reads complete.
- Gapped reads: rden toggling 1,0,1,0 across one entry.
  - Response: valid exactly 1 cycle after each rden=1; idx advances only on accepted reads; 8 words in order.
- Reset mid-drain: after 3 of 8 words read with the second entry full, assert rst 1 cycle.
  - Response: empty=1, words=0, valid=0.
  - A new word loaded afterwards is emitted from its word 0.
